// File: rtl/adv_drc_pkg.sv
// Shared widths, dword-enable constants and FSM states for the completion packer.
package adv_drc_pkg;

  localparam int unsigned DW_W    = 32;
  localparam int unsigned BEAT_DW = 4;
  localparam int unsigned BEAT_W  = DW_W * BEAT_DW;
  localparam int unsigned RES_DW  = 3;
  localparam int unsigned RES_W   = DW_W * RES_DW;
  localparam int unsigned MRG_W   = DW_W * (RES_DW + BEAT_DW);
  localparam int unsigned CNT_W   = 3;

  localparam logic [BEAT_DW-1:0] DWEN_0 = 4'b0000;
  localparam logic [BEAT_DW-1:0] DWEN_1 = 4'b0001;
  localparam logic [BEAT_DW-1:0] DWEN_2 = 4'b0011;
  localparam logic [BEAT_DW-1:0] DWEN_3 = 4'b0111;
  localparam logic [BEAT_DW-1:0] DWEN_4 = 4'b1111;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Thermometer dword enable for a dword count (counts above 4 saturate).
  function automatic logic [BEAT_DW-1:0] thermo(input logic [CNT_W-1:0] n);
    case (n)
      3'd0:    thermo = DWEN_0;
      3'd1:    thermo = DWEN_1;
      3'd2:    thermo = DWEN_2;
      3'd3:    thermo = DWEN_3;
      default: thermo = DWEN_4;
    endcase
  endfunction

endpackage

// File: rtl/dw_thermo_check.sv
// Validates a dword-enable as a non-zero thermometer code from lane0 and
// returns its dword count (0 when illegal).
//   dwen    : dword enable of the incoming beat
//   legal_c : 1 for 0001/0011/0111/1111
//   cnt_c   : number of valid dwords, forced to 0 when illegal
module dw_thermo_check
  import adv_drc_pkg::*;
(
  input  logic [BEAT_DW-1:0] dwen,
  output logic               legal_c,
  output logic [CNT_W-1:0]   cnt_c
);

  always_comb begin
    legal_c = 1'b1;
    cnt_c   = 3'd0;
    case (dwen)
      DWEN_1:  cnt_c = 3'd1;
      DWEN_2:  cnt_c = 3'd2;
      DWEN_3:  cnt_c = 3'd3;
      DWEN_4:  cnt_c = 3'd4;
      default: legal_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpl_dword_packer.sv
// Packs variable-width completion beats into full 4-dword output beats,
// keeping up to 3 leftover dwords between beats and flushing on cpl_last.
//   i_clk, i_rst_n   : clock, synchronous active-low reset
//   cpl_*            : input completion beat (valid/ready handshake)
//   packer_*         : registered output beat strobe, no backpressure
//   err_dwen         : sticky flag for an accepted illegal dword enable
module cpl_dword_packer
  import adv_drc_pkg::*;
#(
  parameter int unsigned P_TAG_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [P_TAG_W-1:0] cpl_tag,
  input  logic [BEAT_W-1:0]  cpl_data,
  input  logic [BEAT_DW-1:0] cpl_dwen,
  input  logic               cpl_last,
  input  logic               cpl_req_done,
  input  logic               cpl_valid,
  output logic               cpl_ready,
  output logic [P_TAG_W-1:0] packer_tag,
  output logic [BEAT_W-1:0]  packer_dout,
  output logic [BEAT_DW-1:0] packer_dout_dwen,
  output logic               packer_valid,
  output logic               packer_done,
  output logic               err_dwen
);

  state_t               state_q, state_d;
  logic [RES_W-1:0]     res_q, res_d;
  logic [1:0]           res_cnt_q, res_cnt_d;
  logic [P_TAG_W-1:0]   res_tag_q, res_tag_d;
  logic                 pend_done_q, pend_done_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic [BEAT_W-1:0]    dout_q, dout_d;
  logic [BEAT_DW-1:0]   dwen_q, dwen_d;
  logic [P_TAG_W-1:0]   tag_q, tag_d;
  logic                 err_q, err_d;

  logic                 legal;
  logic [CNT_W-1:0]     new_cnt;
  logic [CNT_W-1:0]     total;
  logic                 accept;
  logic [BEAT_W-1:0]    lane_mask;
  logic [BEAT_W-1:0]    data_m;
  logic [MRG_W-1:0]     merged;

  dw_thermo_check u_check (
    .dwen    (cpl_dwen),
    .legal_c (legal),
    .cnt_c   (new_cnt)
  );

  // Zero invalid lanes so stale upper dwords never leak into the residual.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < BEAT_DW; i++) begin
      lane_mask[i*DW_W +: DW_W] = {DW_W{cpl_dwen[i]}};
    end
  end

  assign accept = cpl_valid && ready_q;
  assign data_m = legal ? (cpl_data & lane_mask) : '0;
  assign merged = MRG_W'(res_q) | (MRG_W'(data_m) << {res_cnt_q, 5'b0});
  assign total  = CNT_W'(res_cnt_q) + new_cnt;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    res_cnt_d   = res_cnt_q;
    res_tag_d   = res_tag_q;
    pend_done_d = pend_done_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    dout_d      = dout_q;
    dwen_d      = dwen_q;
    tag_d       = tag_q;
    err_d       = err_q;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          tag_d     = cpl_tag;
          res_tag_d = cpl_tag;
          if (!legal) begin
            err_d = 1'b1;
          end
          if (total >= 3'd4) begin
            valid_d   = 1'b1;
            dout_d    = merged[BEAT_W-1:0];
            dwen_d    = DWEN_4;
            res_d     = merged[MRG_W-1:BEAT_W];
            res_cnt_d = 2'(total - 3'd4);
            if (cpl_last) begin
              if (total == 3'd4) begin
                done_d    = cpl_req_done;
                res_d     = '0;
                res_cnt_d = 2'd0;
              end else begin
                // Tail stays in the residual and is emitted from FLUSH.
                state_d     = ST_FLUSH;
                pend_done_d = cpl_req_done;
              end
            end
          end else if (cpl_last) begin
            valid_d   = (total != 3'd0);
            dout_d    = merged[BEAT_W-1:0];
            dwen_d    = thermo(total);
            done_d    = cpl_req_done;
            res_d     = '0;
            res_cnt_d = 2'd0;
          end else begin
            res_d     = merged[RES_W-1:0];
            res_cnt_d = 2'(total);
          end
        end
      end
      ST_FLUSH: begin
        valid_d     = 1'b1;
        dout_d      = BEAT_W'(res_q);
        dwen_d      = thermo({1'b0, res_cnt_q});
        done_d      = pend_done_q;
        tag_d       = res_tag_q;
        res_d       = '0;
        res_cnt_d   = 2'd0;
        pend_done_d = 1'b0;
        state_d     = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    ready_d = (state_d == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_RUN;
      res_q       <= '0;
      res_cnt_q   <= 2'd0;
      res_tag_q   <= '0;
      pend_done_q <= 1'b0;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      dout_q      <= '0;
      dwen_q      <= '0;
      tag_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      res_cnt_q   <= res_cnt_d;
      res_tag_q   <= res_tag_d;
      pend_done_q <= pend_done_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      dout_q      <= dout_d;
      dwen_q      <= dwen_d;
      tag_q       <= tag_d;
      err_q       <= err_d;
    end
  end

  assign cpl_ready        = ready_q;
  assign packer_tag       = tag_q;
  assign packer_dout      = dout_q;
  assign packer_dout_dwen = dwen_q;
  assign packer_valid     = valid_q;
  assign packer_done      = done_q;
  assign err_dwen         = err_q;

endmodule

// File: tb/tb_cpl_dword_packer.sv
// Self-checking bench for cpl_dword_packer: directed scenarios plus a
// randomized run against a dword-queue reference model.
module tb_cpl_dword_packer;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic [7:0]   cpl_tag;
  logic [127:0] cpl_data;
  logic [3:0]   cpl_dwen;
  logic         cpl_last;
  logic         cpl_req_done;
  logic         cpl_valid;
  logic         cpl_ready;
  logic [7:0]   packer_tag;
  logic [127:0] packer_dout;
  logic [3:0]   packer_dout_dwen;
  logic         packer_valid;
  logic         packer_done;
  logic         err_dwen;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         v;
    logic         d;
    logic [127:0] data;
    logic [3:0]   dwen;
    logic [7:0]   tag;
  } ev_t;

  always #5 i_clk = ~i_clk;

  cpl_dword_packer #(.P_TAG_W(8)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .cpl_tag          (cpl_tag),
    .cpl_data         (cpl_data),
    .cpl_dwen         (cpl_dwen),
    .cpl_last         (cpl_last),
    .cpl_req_done     (cpl_req_done),
    .cpl_valid        (cpl_valid),
    .cpl_ready        (cpl_ready),
    .packer_tag       (packer_tag),
    .packer_dout      (packer_dout),
    .packer_dout_dwen (packer_dout_dwen),
    .packer_valid     (packer_valid),
    .packer_done      (packer_done),
    .err_dwen         (err_dwen)
  );

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Apply one beat across a rising edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic v, input logic [7:0] tag, input logic [127:0] data,
                       input logic [3:0] dwen, input logic last, input logic rd);
    cpl_valid    = v;
    cpl_tag      = tag;
    cpl_data     = data;
    cpl_dwen     = dwen;
    cpl_last     = last;
    cpl_req_done = rd;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 128'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    idle();
    idle();
    checks++;
    if ({packer_valid, packer_done, err_dwen, cpl_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got v%b d%b e%b r%b want all 0", packer_valid, packer_done, err_dwen, cpl_ready);
    end
    checks++;
    if ({packer_tag, packer_dout_dwen, packer_dout} !== 140'h0) begin
      errors++;
      $display("FAIL reset_data got tag %h dwen %b dout %h want 0", packer_tag, packer_dout_dwen, packer_dout);
    end
    i_rst_n = 1'b1;
    idle();
    checks++;
    if (cpl_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 1", cpl_ready);
    end
  endtask

  task automatic test_full_beats();
    logic [127:0] d;
    for (int i = 0; i < 4; i++) begin
      d = rand128();
      drive(1'b1, 8'h05, d, 4'b1111, i == 3, i == 3);
      checks++;
      if (packer_valid !== 1'b1 || packer_dout_dwen !== 4'b1111 || packer_dout !== d ||
          packer_tag !== 8'h05) begin
        errors++;
        $display("FAIL full_beat%0d got v%b dwen %b tag %h dout %h want v1 1111 05 %h",
                 i, packer_valid, packer_dout_dwen, packer_tag, packer_dout, d);
      end
      checks++;
      if (packer_done !== (i == 3) || cpl_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_done%0d got done %b ready %b want %b 1", i, packer_done, cpl_ready, i == 3);
      end
    end
    idle();
  endtask

  task automatic test_split_tail();
    logic [127:0] a, b, exp1, exp2;
    a = rand128();
    b = rand128();
    exp1 = {b[31:0], a[95:0]};
    exp2 = {64'h0, b[95:32]};
    drive(1'b1, 8'h12, a, 4'b0111, 1'b0, 1'b0);
    checks++;
    if (packer_valid !== 1'b0 || cpl_ready !== 1'b1) begin
      errors++;
      $display("FAIL split_first got v%b ready %b want v0 ready1", packer_valid, cpl_ready);
    end
    drive(1'b1, 8'h12, b, 4'b0111, 1'b1, 1'b1);
    checks++;
    if (packer_valid !== 1'b1 || packer_dout_dwen !== 4'b1111 || packer_dout !== exp1 ||
        packer_done !== 1'b0 || cpl_ready !== 1'b0 || packer_tag !== 8'h12) begin
      errors++;
      $display("FAIL split_full got v%b dwen %b done %b ready %b tag %h dout %h want 1 1111 0 0 12 %h",
               packer_valid, packer_dout_dwen, packer_done, cpl_ready, packer_tag, packer_dout, exp1);
    end
    idle();
    checks++;
    if (packer_valid !== 1'b1 || packer_dout_dwen !== 4'b0011 || packer_dout !== exp2 ||
        packer_done !== 1'b1 || cpl_ready !== 1'b1 || packer_tag !== 8'h12) begin
      errors++;
      $display("FAIL split_tail got v%b dwen %b done %b ready %b tag %h dout %h want 1 0011 1 1 12 %h",
               packer_valid, packer_dout_dwen, packer_done, cpl_ready, packer_tag, packer_dout, exp2);
    end
    idle();
  endtask

  task automatic test_single();
    logic [127:0] d, f;
    d = rand128();
    drive(1'b1, 8'h33, d, 4'b0001, 1'b1, 1'b1);
    checks++;
    if (packer_valid !== 1'b1 || packer_dout_dwen !== 4'b0001 || packer_dout !== {96'h0, d[31:0]} ||
        packer_done !== 1'b1) begin
      errors++;
      $display("FAIL single got v%b dwen %b done %b dout %h want 1 0001 1 %h",
               packer_valid, packer_dout_dwen, packer_done, packer_dout, {96'h0, d[31:0]});
    end
    f = rand128();
    drive(1'b1, 8'h34, f, 4'b1111, 1'b0, 1'b0);
    checks++;
    if (packer_valid !== 1'b1 || packer_dout !== f) begin
      errors++;
      $display("FAIL single_residual_clear got v%b dout %h want 1 %h", packer_valid, packer_dout, f);
    end
    drive(1'b1, 8'h34, 128'h0, 4'b0000, 1'b1, 1'b1);
    checks++;
    if (packer_valid !== 1'b0 || packer_done !== 1'b1) begin
      errors++;
      $display("FAIL zero_total_done got v%b done %b want v0 d1", packer_valid, packer_done);
    end
  endtask

  task automatic test_err();
    checks++;
    if (err_dwen !== 1'b1) begin
      errors++;
      $display("FAIL err_zero_dwen got %b want 1", err_dwen);
    end
    test_reset();
    drive(1'b1, 8'h40, rand128(), 4'b0101, 1'b0, 1'b0);
    checks++;
    if (err_dwen !== 1'b1 || packer_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_set got err %b v%b want 1 0", err_dwen, packer_valid);
    end
    idle();
    idle();
    checks++;
    if (err_dwen !== 1'b1 || packer_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky got err %b v%b want 1 0", err_dwen, packer_valid);
    end
  endtask

  task automatic test_reset_flush();
    test_reset();
    drive(1'b1, 8'h21, rand128(), 4'b0111, 1'b0, 1'b0);
    drive(1'b1, 8'h21, rand128(), 4'b0111, 1'b1, 1'b1);
    checks++;
    if (cpl_ready !== 1'b0 || packer_valid !== 1'b1) begin
      errors++;
      $display("FAIL rflush_enter got ready %b v%b want 0 1", cpl_ready, packer_valid);
    end
    i_rst_n = 1'b0;
    idle();
    checks++;
    if ({packer_valid, packer_done, err_dwen, cpl_ready, packer_dout_dwen} !== 8'h00 ||
        packer_dout !== 128'h0 || packer_tag !== 8'h00) begin
      errors++;
      $display("FAIL rflush_reset got v%b d%b dwen %b tag %h dout %h want 0",
               packer_valid, packer_done, packer_dout_dwen, packer_tag, packer_dout);
    end
    i_rst_n = 1'b1;
    idle();
    checks++;
    if (cpl_ready !== 1'b1 || packer_valid !== 1'b0 || packer_done !== 1'b0) begin
      errors++;
      $display("FAIL rflush_release got ready %b v%b d%b want 1 0 0", cpl_ready, packer_valid, packer_done);
    end
    idle();
    checks++;
    if (packer_valid !== 1'b0) begin
      errors++;
      $display("FAIL rflush_no_tail got v%b want 0", packer_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0]  dq[$];
    ev_t          exp_q[$];
    ev_t          e, exp_e;
    logic         m_ready, m_err, v, last, rd, acc;
    logic [7:0]   cur_tag;
    logic [127:0] data;
    logic [3:0]   dwen;
    int           n, r;

    test_reset();
    m_ready = 1'b1;
    m_err   = 1'b0;
    cur_tag = 8'($urandom);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      v    = ($urandom_range(0, 3) != 0);
      data = rand128();
      last = ($urandom_range(0, 3) == 0);
      rd   = $urandom_range(0, 1) == 1;
      r    = $urandom_range(0, 19);
      if (r == 0)      dwen = 4'($urandom);
      else if (r == 1) dwen = 4'b0000;
      else             dwen = 4'((1 << $urandom_range(1, 4)) - 1);
      acc = v && m_ready;
      if (acc) begin
        n = 0;
        case (dwen)
          4'b0001: n = 1;
          4'b0011: n = 2;
          4'b0111: n = 3;
          4'b1111: n = 4;
          default: m_err = 1'b1;
        endcase
        for (int i = 0; i < n; i++) dq.push_back(data[32*i +: 32]);
        while (dq.size() >= 4) begin
          e.v = 1'b1; e.d = 1'b0; e.dwen = 4'b1111; e.tag = cur_tag;
          for (int i = 0; i < 4; i++) e.data[32*i +: 32] = dq.pop_front();
          exp_q.push_back(e);
        end
        if (last) begin
          if (dq.size() > 0) begin
            n = dq.size();
            e.v = 1'b1; e.d = 1'b0; e.tag = cur_tag; e.data = '0;
            e.dwen = 4'((1 << n) - 1);
            for (int i = 0; i < n; i++) e.data[32*i +: 32] = dq.pop_front();
            exp_q.push_back(e);
          end
          if (rd) begin
            if (exp_q.size() > 0) begin
              exp_q[exp_q.size()-1].d = 1'b1;
            end else begin
              e.v = 1'b0; e.d = 1'b1; e.dwen = 4'b0; e.tag = cur_tag; e.data = '0;
              exp_q.push_back(e);
            end
          end
        end
      end
      drive(v, cur_tag, data, dwen, last, rd);
      if (acc && last) cur_tag = 8'($urandom);

      if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
      end else begin
        exp_e.v = 1'b0; exp_e.d = 1'b0; exp_e.dwen = 4'b0; exp_e.tag = 8'h0; exp_e.data = '0;
      end
      m_ready = (exp_q.size() == 0);

      checks++;
      if (packer_valid !== exp_e.v || packer_done !== exp_e.d) begin
        errors++;
        $display("FAIL rnd_strobe cyc %0d got v%b d%b want v%b d%b", cyc, packer_valid, packer_done, exp_e.v, exp_e.d);
      end
      if (exp_e.v) begin
        checks++;
        if (packer_dout !== exp_e.data || packer_dout_dwen !== exp_e.dwen || packer_tag !== exp_e.tag) begin
          errors++;
          $display("FAIL rnd_beat cyc %0d got dwen %b tag %h dout %h want %b %h %h",
                   cyc, packer_dout_dwen, packer_tag, packer_dout, exp_e.dwen, exp_e.tag, exp_e.data);
        end
      end
      checks++;
      if (cpl_ready !== m_ready || err_dwen !== m_err) begin
        errors++;
        $display("FAIL rnd_ready_err cyc %0d got ready %b err %b want %b %b", cyc, cpl_ready, err_dwen, m_ready, m_err);
      end
    end
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    idle();
    idle();
  endtask

  initial begin
    i_rst_n = 1'b0;
    cpl_valid = 1'b0; cpl_tag = '0; cpl_data = '0; cpl_dwen = '0;
    cpl_last = 1'b0; cpl_req_done = 1'b0;
    test_reset();
    test_full_beats();
    test_split_tail();
    test_single();
    test_err();
    test_reset_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpl_dword_packer.md
CPL_DWORD_PACKER -- requirements
Module: cpl_dword_packer

Interface
REQ-001 P_TAG_W, 8, completion tag width.
REQ-002 i_clk  in  1  single clock; all logic on rising edge.
REQ-003 i_rst_n  in  1  synchronous, active-low reset.
REQ-004 cpl_tag  in  P_TAG_W  tag of the completion beat.
REQ-005 cpl_data  in  128  payload; dword n in bits [32n+31:32n], dword0 is oldest.
REQ-006 cpl_dwen  in  4  valid dwords, thermometer from lane0 (0001/0011/0111/1111).
REQ-007 cpl_last  in  1  last beat of one completion TLP.
REQ-008 cpl_req_done  in  1  this completion finishes its read request (qualified by cpl_last).
REQ-009 cpl_valid  in  1  beat valid.
REQ-010 cpl_ready  out  1  beat accepted when cpl_valid && cpl_ready.
REQ-011 packer_tag  out  P_TAG_W  tag of output beat.
REQ-012 packer_dout  out  128  packed payload, lane0 oldest.
REQ-013 packer_dout_dwen  out  4  thermometer dword valid; 1111 except on flush.
REQ-014 packer_valid  out  1  one-cycle output beat strobe; no backpressure.
REQ-015 packer_done  out  1  pulses with the final beat of a request.
REQ-016 err_dwen  out  1  sticky: accepted beat had non-thermometer or zero cpl_dwen.

Function
REQ-017 Block SHALL hold a residual buffer of 0..3 dwords (res_cnt) plus res_tag.
REQ-018 On accept, new dwords SHALL be appended above the residual: total = res_cnt + popcount(cpl_dwen), range 0..7.
REQ-019 If total >= 4 the lowest 4 dwords SHALL be output next cycle with dwen 1111; remaining total-4 dwords become the residual.
REQ-020 If cpl_last and total < 4 (total > 0), all dwords SHALL be output next cycle with thermometer dwen of total; residual cleared.
REQ-021 If cpl_last and total == 4, one 1111 beat SHALL be output; residual cleared.
REQ-022 If cpl_last and total in 5..7: cycle N+1 outputs 1111; cycle N+2 outputs the tail (thermometer total-4); FSM SHALL enter FLUSH and drive cpl_ready=0 for exactly one cycle.
REQ-023 FSM states: RUN (cpl_ready=1), FLUSH (cpl_ready=0); RUN->FLUSH only per REQ-022; FLUSH->RUN unconditionally after one cycle.
REQ-024 Output latency SHALL be one cycle from accept; all outputs registered.
REQ-025 packer_tag SHALL equal the accepted cpl_tag; tag change without a prior cpl_last is illegal and unchecked.
REQ-026 packer_done SHALL assert with the last output beat of a completion accepted with cpl_last && cpl_req_done; with total==0 it SHALL still pulse, with packer_valid=0.
REQ-027 A non-last completion ending with total < 4 SHALL retain the residual (no output).
REQ-028 Illegal cpl_dwen SHALL set err_dwen; the beat is treated as dwen 0000.
REQ-029 cpl_valid=0 SHALL leave the residual unchanged; no output.

Reset
REQ-030 While i_rst_n=0: res_cnt=0, FSM=RUN, packer_valid=0, packer_done=0, err_dwen=0, packer_dout_dwen=0, packer_dout=0, packer_tag=0; cpl_ready=0 during reset.
REQ-031 Reset mid-FLUSH SHALL discard the pending tail without emitting it.

Structure
REQ-032 Shared package adv_drc_pkg SHALL hold dword/beat widths, dwen thermometer constants and the FSM state enum.
REQ-033 One sub-module, dw_thermo_check, SHALL validate cpl_dwen and return popcount.

Verification
REQ-034 Four beats dwen 1111, tag 0x05, last+req_done on 4th -> four 1111 outputs, packer_done with 4th, cpl_ready always 1.
REQ-035 Beats 0111, 0111 (last) tag 0x12 -> one 1111 beat (dw0,1,2,3'), one 0011 beat next cycle; cpl_ready low 1 cycle.
REQ-036 Beat 0001 (last, req_done) -> one 0001 beat with packer_done; residual 0.
REQ-037 Beat 0101 -> err_dwen=1 sticky, no output.
REQ-038 Reset asserted during FLUSH -> no tail beat, all outputs 0, cpl_ready=1 one cycle after release.
